// File: rtl/juego_pkg.sv
// Shared types, constants and helpers for the minesweeper game controller.
package juego_pkg;

   localparam int TAM = 8;
   localparam logic [3:0] COD_BOMBA_DEF = 4'hF;

   // Bit positions of the action vector built from the button inputs.
   localparam int B_DER     = 0;
   localparam int B_IZQ     = 1;
   localparam int B_ABAJO   = 2;
   localparam int B_ARRIBA  = 3;
   localparam int B_BANDERA = 4;
   localparam int B_REVELAR = 5;
   localparam int B_INICIAR = 6;
   localparam int NUM_BTN   = 7;

   typedef enum logic [2:0] {
      INICIO,
      JUGANDO,
      LEER,
      EVALUAR,
      PERDIO,
      GANO
   } estado_t;

   function automatic logic [5:0] idx(input logic [2:0] x, input logic [2:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/detector_flanco.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after the input rises.
module detector_flanco (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulso
);

   logic prev_q, prev_d;
   logic pulso_q, pulso_d;

   always_comb begin
      prev_d  = d;
      pulso_d = d & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= 1'b0;
         pulso_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         pulso_q <= pulso_d;
      end
   end

   assign pulso = pulso_q;

endmodule

// File: rtl/control_juego.sv
// Minesweeper game controller: cursor, reveal sequencing, flags, win/lose detection.
// Build option DETECTOR_FLANCO_EN: treat buttons as levels and act once per press.
//
// state   | meaning
// INICIO  | idle, waiting for iniciar
// JUGANDO | accepting one button action per cycle
// LEER    | board read in flight, cursor frozen
// EVALUAR | celda_dato valid, commit reveal result
// PERDIO  | bomb revealed, outputs held
// GANO    | all safe cells revealed, outputs held
module control_juego
   import juego_pkg::*;
#(
   parameter int         NUM_BOMBAS = 10,
   parameter logic [3:0] COD_BOMBA  = COD_BOMBA_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iniciar,
   input  logic        btn_arriba,
   input  logic        btn_abajo,
   input  logic        btn_izq,
   input  logic        btn_der,
   input  logic        btn_revelar,
   input  logic        btn_bandera,
   output logic [2:0]  celda_x,
   output logic [2:0]  celda_y,
   input  logic [3:0]  celda_dato,
   output logic [2:0]  x_jugador,
   output logic [2:0]  y_jugador,
   output logic [63:0] revelados,
   output logic [63:0] banderas,
   output logic [6:0]  cont_revelados,
   output logic        game_over,
   output logic        victoria,
   output logic        jugando
);

   localparam logic [6:0] META   = 7'(TAM * TAM - NUM_BOMBAS);
   localparam logic [2:0] MAX_XY = 3'(TAM - 1);

   logic [NUM_BTN-1:0] btn_in;
   logic [NUM_BTN-1:0] btn;

   assign btn_in = {iniciar, btn_revelar, btn_bandera, btn_arriba,
                    btn_abajo, btn_izq, btn_der};

`ifdef DETECTOR_FLANCO_EN
   for (genvar g = 0; g < NUM_BTN; g++) begin : g_flanco
      detector_flanco u_flanco (
         .clk   (clk),
         .rst   (rst),
         .d     (btn_in[g]),
         .pulso (btn[g])
      );
   end
`else
   assign btn = btn_in;
`endif

   estado_t     estado_q, estado_d;
   logic [2:0]  x_q, x_d, y_q, y_d;
   logic [63:0] rev_q, rev_d, ban_q, ban_d;
   logic [6:0]  cont_q, cont_d;
   logic        go_q, go_d, vic_q, vic_d, jug_q, jug_d;
   logic [5:0]  pos;

   always_comb begin
      estado_d = estado_q;
      x_d      = x_q;
      y_d      = y_q;
      rev_d    = rev_q;
      ban_d    = ban_q;
      cont_d   = cont_q;
      go_d     = go_q;
      vic_d    = vic_q;
      pos      = idx(x_q, y_q);

      case (estado_q)
         INICIO: begin
            if (btn[B_INICIAR]) begin
               estado_d = JUGANDO;
               x_d      = '0;
               y_d      = '0;
               rev_d    = '0;
               ban_d    = '0;
               cont_d   = '0;
               go_d     = 1'b0;
               vic_d    = 1'b0;
            end
         end
         JUGANDO: begin
            // Only the highest-priority button acts; the rest are dropped.
            if (btn[B_REVELAR]) begin
               if (!rev_q[pos] && !ban_q[pos]) estado_d = LEER;
            end else if (btn[B_BANDERA]) begin
               if (!rev_q[pos]) ban_d[pos] = ~ban_q[pos];
            end else if (btn[B_ARRIBA]) begin
               if (y_q != 3'd0) y_d = y_q - 3'd1;
            end else if (btn[B_ABAJO]) begin
               if (y_q != MAX_XY) y_d = y_q + 3'd1;
            end else if (btn[B_IZQ]) begin
               if (x_q != 3'd0) x_d = x_q - 3'd1;
            end else if (btn[B_DER]) begin
               if (x_q != MAX_XY) x_d = x_q + 3'd1;
            end
         end
         LEER: begin
            estado_d = EVALUAR;
         end
         EVALUAR: begin
            rev_d[pos] = 1'b1;
            if (celda_dato == COD_BOMBA) begin
               estado_d = PERDIO;
               go_d     = 1'b1;
            end else begin
               cont_d = cont_q + 7'd1;
               if (cont_d == META) begin
                  estado_d = GANO;
                  vic_d    = 1'b1;
               end else begin
                  estado_d = JUGANDO;
               end
            end
         end
         PERDIO, GANO: begin
            if (btn[B_INICIAR]) begin
               estado_d = INICIO;
               x_d      = '0;
               y_d      = '0;
               rev_d    = '0;
               ban_d    = '0;
               cont_d   = '0;
               go_d     = 1'b0;
               vic_d    = 1'b0;
            end
         end
         default: begin
            estado_d = INICIO;
         end
      endcase

      jug_d = (estado_d == JUGANDO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= INICIO;
         x_q      <= '0;
         y_q      <= '0;
         rev_q    <= '0;
         ban_q    <= '0;
         cont_q   <= '0;
         go_q     <= 1'b0;
         vic_q    <= 1'b0;
         jug_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         x_q      <= x_d;
         y_q      <= y_d;
         rev_q    <= rev_d;
         ban_q    <= ban_d;
         cont_q   <= cont_d;
         go_q     <= go_d;
         vic_q    <= vic_d;
         jug_q    <= jug_d;
      end
   end

   assign celda_x        = x_q;
   assign celda_y        = y_q;
   assign x_jugador      = x_q;
   assign y_jugador      = y_q;
   assign revelados      = rev_q;
   assign banderas       = ban_q;
   assign cont_revelados = cont_q;
   assign game_over      = go_q;
   assign victoria       = vic_q;
   assign jugando        = jug_q;

endmodule
